// File: rtl/game_stats_counter.sv
// Game statistics for the seven-segment display stage: play seconds, snake length,
// a start/pause/game-over state machine and the free-running display scan clock.
module game_stats_counter #(
    parameter int unsigned CLK_HZ      = 100000000,
    parameter int unsigned SCAN_DIV    = 50000,
    parameter int unsigned INIT_LEN    = 3,
    parameter int unsigned MAX_LEN     = 99,
    parameter int unsigned MAX_SECONDS = 5999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        pause_toggle,
    input  logic        game_over,
    input  logic        eat,
    output logic [15:0] seconds,
    output logic [12:0] length,
    output logic        running,
    output logic        scan_clk
);

    localparam int PS_W  = (CLK_HZ > 1)   ? $clog2(CLK_HZ)   : 1;
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(CLK_HZ - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [15:0]      SEC_MAX  = 16'(MAX_SECONDS);
    localparam logic [12:0]      LEN_MAX  = 13'(MAX_LEN);
    localparam logic [12:0]      LEN_INIT = 13'(INIT_LEN);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_OVER  = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             start_game;
    logic             in_run;
    logic             tick;
    logic [PS_W-1:0]  prescale;
    logic [DIV_W-1:0] scan_div;

    // Comparing before incrementing keeps the counters from ever passing their limits.
    function automatic logic [15:0] sat_inc_sec(input logic [15:0] v);
        return (v < SEC_MAX) ? v + 16'd1 : v;
    endfunction

    function automatic logic [12:0] sat_inc_len(input logic [12:0] v);
        return (v < LEN_MAX) ? v + 13'd1 : v;
    endfunction

    assign in_run = (state == S_RUN);
    assign tick   = in_run && (prescale == PS_LAST);

    // Priority chain game_over > pause_toggle > start; a losing pulse is dropped
    // even when the winning one has no effect in the current state.
    always_comb begin
        state_nxt  = state;
        start_game = 1'b0;
        if (game_over) begin
            if (state == S_RUN || state == S_PAUSE)
                state_nxt = S_OVER;
        end else if (pause_toggle) begin
            if (state == S_RUN)
                state_nxt = S_PAUSE;
            else if (state == S_PAUSE)
                state_nxt = S_RUN;
        end else if (start) begin
            if (state == S_IDLE || state == S_OVER) begin
                state_nxt  = S_RUN;
                start_game = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            running  <= 1'b0;
            seconds  <= 16'd0;
            length   <= LEN_INIT;
            prescale <= '0;
            scan_div <= '0;
            scan_clk <= 1'b0;
        end else begin
            state   <= state_nxt;
            running <= (state_nxt == S_RUN);

            // Counting follows the current state, so an eat or tick arriving with
            // game_over or pause_toggle still lands before the state changes.
            if (start_game) begin
                seconds  <= 16'd0;
                length   <= LEN_INIT;
                prescale <= '0;
            end else if (in_run) begin
                prescale <= tick ? '0 : prescale + PS_W'(1);
                if (tick)
                    seconds <= sat_inc_sec(seconds);
                if (eat)
                    length <= sat_inc_len(length);
            end

            if (scan_div == DIV_LAST) begin
                scan_div <= '0;
                scan_clk <= ~scan_clk;
            end else begin
                scan_div <= scan_div + DIV_W'(1);
            end
        end
    end

endmodule
